// File: rtl/seg7_pkg.sv
// Shared glyph constants and FSM encoding for the seven-segment capture block.
// Segment order is a..g from bit 6 down to bit 0, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef logic [1:0] state_t;

    localparam state_t S_WAIT  = 2'd0;
    localparam state_t S_TRACK = 2'd1;
    localparam state_t S_HOLD  = 2'd2;

endpackage

// File: rtl/seven_segment_capture_if.sv
// Multiplexed seven-segment bus in, recovered BCD frame out.
// master drives the display bus, slave is the capture block.
interface seven_segment_capture_if #(
    parameter int DIGITS = 4
) ();

    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   dig_sel;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_err;
    logic                err_out;
    logic                valid_out;

    modport master (
        output seg_in, dig_sel,
        input  bcd_out, digit_err, err_out, valid_out
    );

    modport slave (
        input  seg_in, dig_sel,
        output bcd_out, digit_err, err_out, valid_out
    );

endinterface

// File: rtl/seven_segment_pattern_decode.sv
// Combinational glyph-to-BCD decoder; anything that is not a 0-9 glyph
// (blank included) returns BCD_INVALID with legal low.
module seven_segment_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       legal
);

    always_comb begin
        bcd   = BCD_INVALID;
        legal = 1'b1;
        case (pattern)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers BCD frames from a multiplexed seven-segment bus.
// Define SEG_CAPTURE_LOWACT_EN for a common-anode (active-low) bus.
module seven_segment_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input logic                    clk,
    input logic                    rst,
    seven_segment_capture_if.slave bus
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] THRESH = CW'(STABLE_CYCLES);

    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   sel_d;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   sel_q;
    logic [CW-1:0]       stab_cnt;
    state_t              state;
    logic [DIGITS-1:0]   cap_mask;
    logic [4*DIGITS-1:0] shadow_bcd;
    logic [DIGITS-1:0]   shadow_err;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   derr_q;
    logic                err_q;
    logic                valid_q;
    logic [3:0]          dec_bcd;
    logic                dec_legal;
    logic                sel_hot;
    logic                same;
    logic                cap;
    logic                full;

`ifdef SEG_CAPTURE_LOWACT_EN
    assign seg_d = ~bus.seg_in;
    assign sel_d = ~bus.dig_sel;
`else
    assign seg_d = bus.seg_in;
    assign sel_d = bus.dig_sel;
`endif

    assign sel_hot = $onehot(sel_d);
    assign same    = (seg_d == seg_q) && (sel_d == sel_q);
    // Capture fires on the edge after the count hit threshold, even if the
    // bus moves on at that same edge; seg_q still holds the stable glyph.
    assign cap     = (state == S_TRACK) && (stab_cnt == THRESH);
    assign full    = &cap_mask;

    seven_segment_pattern_decode u_dec (
        .pattern (seg_q),
        .bcd     (dec_bcd),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            sel_q      <= '0;
            stab_cnt   <= '0;
            state      <= S_WAIT;
            cap_mask   <= '0;
            shadow_bcd <= '0;
            shadow_err <= '0;
            bcd_q      <= '0;
            derr_q     <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            valid_q <= full;

            if (cap) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel_q[i]) begin
                        shadow_bcd[4*i +: 4] <= dec_bcd;
                        shadow_err[i]        <= !dec_legal;
                    end
                end
            end

            // A capture landing on the publish edge seeds the next frame.
            cap_mask <= (full ? '0 : cap_mask) | (cap ? sel_q : '0);

            if (full) begin
                bcd_q  <= shadow_bcd;
                derr_q <= shadow_err;
                err_q  <= |shadow_err;
            end

            case (state)
                S_WAIT: begin
                    if (sel_hot) begin
                        state    <= S_TRACK;
                        stab_cnt <= CW'(1);
                    end
                end
                S_TRACK: begin
                    if (!sel_hot) begin
                        state    <= S_WAIT;
                        stab_cnt <= '0;
                    end else if (!same) begin
                        stab_cnt <= CW'(1);
                    end else if (cap) begin
                        state <= S_HOLD;
                    end else begin
                        stab_cnt <= stab_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (!sel_hot) begin
                        state    <= S_WAIT;
                        stab_cnt <= '0;
                    end else if (!same) begin
                        state    <= S_TRACK;
                        stab_cnt <= CW'(1);
                    end
                end
                default: begin
                    state    <= S_WAIT;
                    stab_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.bcd_out   = bcd_q;
    assign bus.digit_err = derr_q;
    assign bus.err_out   = err_q;
    assign bus.valid_out = valid_q;

endmodule

// File: doc/seven_segment_capture.md
# seven_segment_capture

Receive-side counterpart of the BCD-to-seven-segment encoder: it samples a multiplexed seven-segment bus (segment lines plus one-hot digit select) and recovers the BCD digits being displayed. The block waits for each digit's pattern to be stable, decodes it back to BCD and collects one value per digit. When every digit has been captured, it publishes the whole frame with a one-cycle valid pulse. It sits on the display-monitor path, for self-check and loopback of the display driver.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions, range 1–8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured, range ≥ 2.
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `seg_in` input, 7 bits: segment lines, bit 6 = a … bit 0 = g, active-high.
- `dig_sel` input, `DIGITS` bits: digit select, active-high, expected one-hot.
- `bcd_out` output, `4*DIGITS` bits: published frame; digit i is at `[4i+3:4i]`.
- `digit_err` output, `DIGITS` bits: per-digit flag, set when that digit's pattern was not a legal 0–9 glyph.
- `err_out` output, 1 bit: OR of `digit_err`, updated with the frame.
- `valid_out` output, 1 bit: one-cycle pulse when a new frame is published.

## Operation
- **Legal glyphs (a..g):**
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any other pattern, including blank 0000000, decodes to 4'hF with its error bit set.
- **Sample registers:**
  - `seg_q` and `sel_q` register the inputs every cycle.
  - Stability counter `stab_cnt` has width clog2(`STABLE_CYCLES`)+1.
- **FSM states:** WAIT, TRACK, HOLD.
  - **WAIT:** `dig_sel` is zero or not one-hot. `stab_cnt` is 0. Move to TRACK when `dig_sel` is one-hot.
  - **TRACK:** if `seg_in`==`seg_q` and `dig_sel`==`sel_q`, increment `stab_cnt`. Otherwise reset `stab_cnt` to 1, or go to WAIT if `dig_sel` is not one-hot. When `stab_cnt` reaches `STABLE_CYCLES`, decode `seg_q` into shadow slot idx(`sel_q`), set `cap_mask[idx]`, and go to HOLD.
  - **HOLD:** stays until `seg_in` or `dig_sel` changes, then goes to TRACK (or WAIT), so there is at most one capture per dwell.
- **Recapture:** capturing a digit whose `cap_mask` bit is already set overwrites its shadow slot.
- **Publish:** the cycle after `cap_mask` becomes all-ones:
  - shadow → `bcd_out` and shadow errors → `digit_err`;
  - `err_out` is updated;
  - `valid_out` is asserted for 1 cycle;
  - `cap_mask` is cleared.
  - A capture in the publish cycle is kept and counts toward the next frame.
- **Between publishes:** `bcd_out`, `digit_err` and `err_out` hold their values.

## Timing
- **Reset values:** `bcd_out`=0, `digit_err`=0, `err_out`=0, `valid_out`=0. Shadow registers, `cap_mask` and `stab_cnt` clear; FSM goes to WAIT.
- **Capture latency:** the capture edge is `STABLE_CYCLES` cycles after the first sample of a new (`dig_sel`, `seg_in`) pair.
- **Publish latency:** `valid_out` rises 1 cycle after the last digit's capture edge.
- **Change on the threshold cycle:** if the input changes in the cycle where `stab_cnt` would reach threshold, there is no capture and the count restarts.
- **Reset mid-frame:** partial captures are discarded. No `valid_out` is produced for that frame.
- **Counter saturation:** `stab_cnt` saturates at `STABLE_CYCLES` and never wraps.

## Configuration
- **`SEG_CAPTURE_LOWACT_EN` defined:** `seg_in` and `dig_sel` are inverted at the input register, for a common-anode, active-low bus. All internal logic is unchanged.
- **Not defined:** inputs are active-high as specified above.

## Structure
- **Package `seg7_pkg`:**
  - glyph constants `SEG_0`…`SEG_9` and `SEG_BLANK`;
  - `BCD_INVALID` = 4'hF;
  - FSM state typedef (WAIT/TRACK/HOLD).
- **Sub-module `seven_segment_pattern_decode`:** combinational, 7-bit pattern → 4-bit BCD plus `legal` flag. It is instantiated once, on `seg_q`.

## Test plan
- Defaults (DIGITS=4, STABLE_CYCLES=4); scan digits 0..3 with glyphs for 1,2,3,4, each held 6 cycles → `valid_out` pulses once, `bcd_out`=16'h4321, `err_out`=0.
- Digit 2 held for only 3 cycles → no capture; `valid_out` only after digit 2 later dwells ≥4 cycles.
- Digit 1 shows 0000000 → `bcd_out[7:4]`=4'hF, `digit_err`=4'b0010, `err_out`=1.
- `dig_sel`=4'b0110 for 10 cycles → no capture, `valid_out` stays 0.
- `rst` asserted after 3 of 4 digits are captured, then a full scan of 9,8,7,6 → a single frame with `bcd_out`=16'h6789, and no stale data published.
- Build with `SEG_CAPTURE_LOWACT_EN`; inverted stimulus of test 1 → identical `bcd_out`=16'h4321.
